output_token_writer: RTL and testbench

Transmit-side counterpart of the firing-state FSM's input memory controllers. It captures the 32-bit result and status tokens when the actor pulses its output-write enable, and serialises each token into two word_size words. The low word goes out first, then the high word, into the output result FIFO and the output status FIFO in lock-step. It sits between the firing-state FSM and the two output FIFOs, and gates writes on FIFO population so that a token pair is never split by a full FIFO.

---
 rtl/output_token_writer_if.sv | 40 ++++
 rtl/output_token_writer.sv | 111 +++++++++++
 tb/tb_output_token_writer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_token_writer_if.sv
// ============================================================================
// Module      : output_token_writer_if
// Description : Load/FIFO-write bundle between the firing-state FSM, the
//               output token writer and the two output FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface output_token_writer_if #(
   parameter int WORD_SIZE = 16
);
   logic                     en_wr_output_fifo;
   logic [2*WORD_SIZE-1:0]   result;
   logic [2*WORD_SIZE-1:0]   status;
   logic [WORD_SIZE-1:0]     pop_out_fifo_result;
   logic [WORD_SIZE-1:0]     pop_out_fifo_status;
   logic                     wr_out_result;
   logic                     wr_out_status;
   logic [WORD_SIZE-1:0]     data_out_result;
   logic [WORD_SIZE-1:0]     data_out_status;
   logic                     ready;
   logic                     done_out;
   logic                     dropped;

   modport master (
      output en_wr_output_fifo, result, status,
             pop_out_fifo_result, pop_out_fifo_status,
      input  wr_out_result, wr_out_status, data_out_result, data_out_status,
             ready, done_out, dropped
   );

   modport slave (
      input  en_wr_output_fifo, result, status,
             pop_out_fifo_result, pop_out_fifo_status,
      output wr_out_result, wr_out_status, data_out_result, data_out_status,
             ready, done_out, dropped
   );
endinterface

`default_nettype wire

// File: rtl/output_token_writer.sv
// ============================================================================
// Module      : output_token_writer
// Description : Latches result/status tokens and writes each as low then high
//               word into the result and status FIFOs in lock-step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_token_writer #(
   parameter int WORD_SIZE   = 16,
   parameter int BUFFER_SIZE = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   output_token_writer_if.slave bus
);

   localparam int FW = WORD_SIZE + 1;

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_CHECK = 3'd1;
   localparam logic [2:0] c_WR_LO = 3'd2;
   localparam logic [2:0] c_WR_HI = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   localparam logic [FW-1:0] c_BUF_SIZE = FW'(BUFFER_SIZE);
   localparam logic [FW-1:0] c_PAIR     = FW'(2);

   logic [2:0]             r_state;
   logic [2*WORD_SIZE-1:0] r_result;
   logic [2*WORD_SIZE-1:0] r_status;
   logic                   r_dropped;

   logic [FW-1:0]          w_pop_result;
   logic [FW-1:0]          w_pop_status;
   logic [FW-1:0]          w_free_result;
   logic [FW-1:0]          w_free_status;
   logic                   w_space_ok;
   logic                   w_ready;

   // A population beyond capacity is treated as a full FIFO, not wrapped.
   assign w_pop_result  = {1'b0, bus.pop_out_fifo_result};
   assign w_pop_status  = {1'b0, bus.pop_out_fifo_status};
   assign w_free_result = (w_pop_result > c_BUF_SIZE) ? '0 : (c_BUF_SIZE - w_pop_result);
   assign w_free_status = (w_pop_status > c_BUF_SIZE) ? '0 : (c_BUF_SIZE - w_pop_status);
   assign w_space_ok    = (w_free_result >= c_PAIR) && (w_free_status >= c_PAIR);
   assign w_ready       = (r_state == c_IDLE) || (r_state == c_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= c_IDLE;
         r_result  <= '0;
         r_status  <= '0;
         r_dropped <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE, c_DONE: begin
               if (bus.en_wr_output_fifo) begin
                  r_result <= bus.result;
                  r_status <= bus.status;
                  r_state  <= c_CHECK;
               end else begin
                  r_state  <= c_IDLE;
               end
            end
            c_CHECK: begin
               if (w_space_ok) begin
                  r_state <= c_WR_LO;
               end
            end
            c_WR_LO: r_state <= c_WR_HI;
            c_WR_HI: r_state <= c_DONE;
            default: r_state <= c_IDLE;
         endcase

         if (bus.en_wr_output_fifo && !w_ready) begin
            r_dropped <= 1'b1;
         end
      end
   end

   // Outputs depend only on registered state, never on the load strobe.
   always_comb begin
      bus.wr_out_result   = 1'b0;
      bus.wr_out_status   = 1'b0;
      bus.data_out_result = '0;
      bus.data_out_status = '0;
      case (r_state)
         c_WR_LO: begin
            bus.wr_out_result   = 1'b1;
            bus.wr_out_status   = 1'b1;
            bus.data_out_result = r_result[WORD_SIZE-1:0];
            bus.data_out_status = r_status[WORD_SIZE-1:0];
         end
         c_WR_HI: begin
            bus.wr_out_result   = 1'b1;
            bus.wr_out_status   = 1'b1;
            bus.data_out_result = r_result[2*WORD_SIZE-1:WORD_SIZE];
            bus.data_out_status = r_status[2*WORD_SIZE-1:WORD_SIZE];
         end
         default: ;
      endcase
   end

   assign bus.ready    = w_ready;
   assign bus.done_out = (r_state == c_DONE);
   assign bus.dropped  = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_output_token_writer.sv
// Bench for output_token_writer: a job-level model checked every cycle,
// plus literal cycle-by-cycle expectations from hand-worked scenarios.
`timescale 1ns/1ps
`default_nettype none

module tb_output_token_writer;
   localparam int WS = 16;
   localparam int BS = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   output_token_writer_if #(.WORD_SIZE(WS)) bus ();

   output_token_writer #(.WORD_SIZE(WS), .BUFFER_SIZE(BS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- job-level model ----------------
   bit        m_job, m_granted, m_done, m_drop, m_accept;
   int        m_sent;
   bit [31:0] m_r, m_s;

   function automatic int free_of(input logic [15:0] p);
      return (int'(p) > BS) ? 0 : BS - int'(p);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_job = 0; m_granted = 0; m_done = 0; m_drop = 0; m_sent = 0;
         m_r = '0; m_s = '0;
      end else begin
         m_accept = bus.en_wr_output_fifo && !m_job;
         if (bus.en_wr_output_fifo && m_job) m_drop = 1;
         m_done = 0;
         if (m_job) begin
            if (!m_granted) begin
               m_granted = (free_of(bus.pop_out_fifo_result) >= 2) &&
                           (free_of(bus.pop_out_fifo_status) >= 2);
            end else begin
               m_sent++;
               if (m_sent == 2) begin
                  m_job  = 0;
                  m_done = 1;
               end
            end
         end
         if (m_accept) begin
            m_job = 1; m_granted = 0; m_sent = 0;
            m_r = bus.result; m_s = bus.status;
         end
      end
   end

   always @(negedge clk) begin
      bit        e_wr;
      bit [15:0] e_dr, e_ds;
      if (cmp_on) begin
         e_wr = m_job && m_granted;
         e_dr = !e_wr ? 16'h0 : (m_sent == 0 ? m_r[15:0] : m_r[31:16]);
         e_ds = !e_wr ? 16'h0 : (m_sent == 0 ? m_s[15:0] : m_s[31:16]);
         chk("m_wr_result",   bus.wr_out_result,   e_wr);
         chk("m_wr_status",   bus.wr_out_status,   e_wr);
         chk("m_data_result", bus.data_out_result, e_dr);
         chk("m_data_status", bus.data_out_status, e_ds);
         chk("m_ready",       bus.ready,           !m_job);
         chk("m_done",        bus.done_out,        m_done);
         chk("m_dropped",     bus.dropped,         m_drop);
      end
   end

   // ---------------- FIFO write capture ----------------
   int          n_wr = 0;
   logic [15:0] q_r[$];
   logic [15:0] q_s[$];
   always @(posedge clk) begin
      if (bus.wr_out_result) begin
         n_wr++;
         q_r.push_back(bus.data_out_result);
         q_s.push_back(bus.data_out_status);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [31:0] r, input logic [31:0] s);
      bus.en_wr_output_fifo = 1'b1;
      bus.result = r;
      bus.status = s;
      cyc();
      bus.en_wr_output_fifo = 1'b0;
      bus.result = ~r;
      bus.status = ~s;
   endtask

   task automatic wait_ready(input int lim);
      int k = 0;
      while (!bus.ready && k < lim) begin
         cyc();
         k++;
      end
      chk("wait_ready", bus.ready, 1'b1);
   endtask

   task automatic chk_pair(input string name, input int idx, input logic [31:0] r, input logic [31:0] s);
      logic [15:0] a0, a1, b0, b1;
      a0 = (q_r.size() > idx)     ? q_r[idx]     : 16'hxxxx;
      a1 = (q_r.size() > idx + 1) ? q_r[idx + 1] : 16'hxxxx;
      b0 = (q_s.size() > idx)     ? q_s[idx]     : 16'hxxxx;
      b1 = (q_s.size() > idx + 1) ? q_s[idx + 1] : 16'hxxxx;
      chk({name, "_res"}, {a1, a0}, r);
      chk({name, "_sts"}, {b1, b0}, s);
   endtask

   int base;

   initial begin
      bus.en_wr_output_fifo   = 1'b0;
      bus.result              = '0;
      bus.status              = '0;
      bus.pop_out_fifo_result = '0;
      bus.pop_out_fifo_status = '0;
      cyc();
      cmp_on = 1'b1;
      cyc();
      chk("rst_ready", bus.ready, 1'b1);
      chk("rst_wr",    {bus.wr_out_result, bus.wr_out_status}, 2'b00);
      chk("rst_data",  {bus.data_out_result, bus.data_out_status}, 32'h0);
      chk("rst_done_drop", {bus.done_out, bus.dropped}, 2'b00);
      rst = 1'b1;
      cyc();

      // Single token
      base = n_wr;
      load(32'h1234ABCD, 32'h0000_0001);
      chk("t1_c1_wr",    bus.wr_out_result, 1'b0);
      chk("t1_c1_ready", bus.ready, 1'b0);
      cyc();
      chk("t1_c2_wr",    {bus.wr_out_result, bus.wr_out_status}, 2'b11);
      chk("t1_c2_res",   bus.data_out_result, 16'hABCD);
      chk("t1_c2_sts",   bus.data_out_status, 16'h0001);
      cyc();
      chk("t1_c3_res",   bus.data_out_result, 16'h1234);
      chk("t1_c3_sts",   bus.data_out_status, 16'h0000);
      cyc();
      chk("t1_c4_done",  bus.done_out, 1'b1);
      chk("t1_c4_wr",    bus.wr_out_result, 1'b0);
      cyc();
      chk("t1_c5_done",  bus.done_out, 1'b0);
      chk("t1_c5_ready", bus.ready, 1'b1);
      chk("t1_nwr",      n_wr - base, 2);

      // Back-to-back
      base = n_wr;
      load(32'hAAAA_5555, 32'h1111_2222);
      cyc(); cyc(); cyc();
      chk("t2_c4_done", bus.done_out, 1'b1);
      load(32'hDEAD_BEEF, 32'hCAFE_F00D);
      cyc();
      chk("t2_c6_wr",  bus.wr_out_result, 1'b1);
      chk("t2_c6_res", bus.data_out_result, 16'hBEEF);
      wait_ready(10);
      cyc();
      chk("t2_dropped", bus.dropped, 1'b0);
      chk("t2_nwr", n_wr - base, 4);
      chk_pair("t2_first",  base,     32'hAAAA_5555, 32'h1111_2222);
      chk_pair("t2_second", base + 2, 32'hDEAD_BEEF, 32'hCAFE_F00D);

      // Full stall on status FIFO
      base = n_wr;
      bus.pop_out_fifo_status = 16'd1023;
      load(32'h0BAD_F00D, 32'h7777_8888);
      for (int i = 0; i < 10; i++) begin
         chk("t3_stall_wr",    bus.wr_out_result | bus.wr_out_status, 1'b0);
         chk("t3_stall_ready", bus.ready, 1'b0);
         cyc();
      end
      bus.pop_out_fifo_status = 16'd1022;
      cyc();
      chk("t3_lo_res", bus.data_out_result, 16'hF00D);
      chk("t3_lo_sts", bus.data_out_status, 16'h8888);
      wait_ready(10);
      cyc();
      bus.pop_out_fifo_status = '0;
      chk_pair("t3_words", base, 32'h0BAD_F00D, 32'h7777_8888);

      // Overflow-range population
      base = n_wr;
      bus.pop_out_fifo_result = 16'hFFFF;
      load(32'h1357_2468, 32'h9ABC_DEF0);
      for (int i = 0; i < 6; i++) begin
         chk("t4_stall_wr",    bus.wr_out_result, 1'b0);
         chk("t4_stall_ready", bus.ready, 1'b0);
         cyc();
      end
      chk("t4_nwr_stall", n_wr - base, 0);
      bus.pop_out_fifo_result = '0;
      cyc();
      chk("t4_lo_res", bus.data_out_result, 16'h2468);
      wait_ready(10);
      cyc();

      // Dropped load during WR_LO
      base = n_wr;
      load(32'h0102_0304, 32'h0506_0708);
      cyc();
      load(32'hFFFF_EEEE, 32'hDDDD_CCCC);
      chk("t5_dropped_set", bus.dropped, 1'b1);
      chk("t5_hi_res", bus.data_out_result, 16'h0102);
      wait_ready(10);
      cyc(); cyc();
      chk("t5_dropped_sticky", bus.dropped, 1'b1);
      chk("t5_nwr", n_wr - base, 2);
      chk_pair("t5_words", base, 32'h0102_0304, 32'h0506_0708);

      // Reset during WR_HI
      base = n_wr;
      load(32'h4444_3333, 32'h2222_1111);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_rst_wr",    {bus.wr_out_result, bus.wr_out_status}, 2'b00);
      chk("t6_rst_data",  {bus.data_out_result, bus.data_out_status}, 32'h0);
      chk("t6_rst_flags", {bus.ready, bus.done_out, bus.dropped}, 3'b100);
      cyc(); cyc();
      chk("t6_nwr_rst", n_wr - base, 1);
      rst = 1'b1;
      cyc();
      base = n_wr;
      load(32'h6666_5555, 32'h8888_7777);
      cyc();
      chk("t6_after_lo", bus.data_out_status, 16'h7777);
      wait_ready(10);
      cyc();
      chk("t6_dropped", bus.dropped, 1'b0);
      chk_pair("t6_words", base, 32'h6666_5555, 32'h8888_7777);

      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
